// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared limits and lane event counting for the parking occupancy tracker
package parking_pkg;

    localparam int MAX_LANES    = 4;
    localparam int MAX_CAPACITY = 255;

    function automatic logic [2:0] popcount_lanes(input logic [MAX_LANES-1:0] lanes);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + 3'(lanes[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sense_edge_sync.sv
// rtl/sense_edge_sync.sv - 3-flop synchroniser with rising-edge detect, flops reset to one
module sense_edge_sync
    import parking_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sense,
    output logic rise
);

    logic s1, s2, s3;

    // Reset-to-one keeps a sensor held high across reset release from looking like a new car.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= sense;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/parking_occupancy_tracker.sv
// rtl/parking_occupancy_tracker.sv - multi-lane car park occupancy tracker with entry arbitration
// Optional peak-occupancy register enabled by defining OCC_PEAK_EN.
module parking_occupancy_tracker
    import parking_pkg::*;
#(
    parameter int CAPACITY  = 40,
    parameter int N_LANES   = 2,
    parameter int AF_MARGIN = 4,
    localparam int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LANES-1:0] entry_sense,
    input  logic [N_LANES-1:0] exit_sense,
    input  logic               err_clear,
    output logic [N_LANES-1:0] entry_grant,
    output logic [N_LANES-1:0] entry_denied,
    output logic [CNT_W-1:0]   occupancy,
    output logic [CNT_W-1:0]   free_slots,
    output logic               empty,
    output logic               full,
    output logic               almost_full,
    output logic               underflow_err,
    output logic [CNT_W-1:0]   peak_occupancy
);

    localparam int AW = CNT_W + 3;

    logic [N_LANES-1:0] entry_ev, exit_ev;

    for (genvar i = 0; i < N_LANES; i++) begin : g_sync
        sense_edge_sync u_entry_sync (.clk(clk), .reset(reset), .sense(entry_sense[i]), .rise(entry_ev[i]));
        sense_edge_sync u_exit_sync  (.clk(clk), .reset(reset), .sense(exit_sense[i]),  .rise(exit_ev[i]));
    end

    logic [AW-1:0]      exit_cnt, occ_cur, valid_exits, avail, granted, occ_wide;
    logic [N_LANES-1:0] grant_next, denied_next;
    logic [CNT_W-1:0]   occ_next;
    logic               underflow_set;

    // Exits are resolved first so space freed this cycle is offered to same-cycle entries.
    always_comb begin
        grant_next    = '0;
        denied_next   = '0;
        granted       = '0;
        exit_cnt      = AW'(popcount_lanes(MAX_LANES'(exit_ev)));
        occ_cur       = AW'(occupancy);
        underflow_set = exit_cnt > occ_cur;
        valid_exits   = underflow_set ? occ_cur : exit_cnt;
        avail         = AW'(CAPACITY) - (occ_cur - valid_exits);
        for (int i = 0; i < N_LANES; i++) begin
            if (entry_ev[i]) begin
                if (granted < avail) begin
                    grant_next[i] = 1'b1;
                    granted       = granted + AW'(1);
                end else begin
                    denied_next[i] = 1'b1;
                end
            end
        end
        occ_wide = occ_cur - valid_exits + granted;
        occ_next = CNT_W'(occ_wide);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_grant   <= '0;
            entry_denied  <= '0;
            occupancy     <= '0;
            free_slots    <= CNT_W'(CAPACITY);
            empty         <= 1'b1;
            full          <= 1'b0;
            almost_full   <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            entry_grant   <= grant_next;
            entry_denied  <= denied_next;
            occupancy     <= occ_next;
            free_slots    <= CNT_W'(CAPACITY) - occ_next;
            empty         <= occ_wide == '0;
            full          <= occ_wide == AW'(CAPACITY);
            almost_full   <= occ_wide + AW'(AF_MARGIN) >= AW'(CAPACITY);
            underflow_err <= underflow_set | (underflow_err & ~err_clear);
        end
    end

`ifdef OCC_PEAK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_occupancy <= '0;
        end else if (occ_next > peak_occupancy) begin
            peak_occupancy <= occ_next;
        end
    end
`else
    assign peak_occupancy = '0;
`endif

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// tb/tb_parking_occupancy_tracker.sv - directed self-checking bench for parking_occupancy_tracker
module tb_parking_occupancy_tracker;

    localparam int CAPACITY  = 8;
    localparam int N_LANES   = 2;
    localparam int AF_MARGIN = 2;
    localparam int CNT_W     = $clog2(CAPACITY + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic [N_LANES-1:0] entry_sense, exit_sense;
    logic               err_clear;
    logic [N_LANES-1:0] entry_grant, entry_denied;
    logic [CNT_W-1:0]   occupancy, free_slots, peak_occupancy;
    logic               empty, full, almost_full, underflow_err;

    int n_cmp = 0;
    int n_err = 0;

    parking_occupancy_tracker #(
        .CAPACITY (CAPACITY),
        .N_LANES  (N_LANES),
        .AF_MARGIN(AF_MARGIN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .entry_sense   (entry_sense),
        .exit_sense    (exit_sense),
        .err_clear     (err_clear),
        .entry_grant   (entry_grant),
        .entry_denied  (entry_denied),
        .occupancy     (occupancy),
        .free_slots    (free_slots),
        .empty         (empty),
        .full          (full),
        .almost_full   (almost_full),
        .underflow_err (underflow_err),
        .peak_occupancy(peak_occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise levels and wait until the resulting events are visible on the outputs.
    task automatic apply(input logic [1:0] en, input logic [1:0] ex);
        entry_sense = en;
        exit_sense  = ex;
        repeat (3) tick();
    endtask

    task automatic release_all();
        entry_sense = '0;
        exit_sense  = '0;
        repeat (3) tick();
    endtask

    task automatic step(input logic [1:0] en, input logic [1:0] ex);
        apply(en, ex);
        release_all();
    endtask

    initial begin
        reset       = 1'b1;
        entry_sense = 2'b11;
        exit_sense  = 2'b00;
        err_clear   = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (4) tick();
        check("rst_occ", occupancy, 0);
        check("rst_empty", empty, 1);
        check("rst_free", free_slots, 8);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_grant", entry_grant, 0);
        check("rst_uf", underflow_err, 0);
        check("rst_peak", peak_occupancy, 0);
        release_all();
        check("held_no_event", occupancy, 0);

        entry_sense = 2'b01;
        repeat (2) tick();
        check("lat_occ_k1", occupancy, 0);
        check("lat_grant_k1", entry_grant, 0);
        tick();
        check("grant0", entry_grant, 2'b01);
        check("occ1", occupancy, 1);
        check("occ1_empty", empty, 0);
        check("occ1_free", free_slots, 7);
        repeat (3) tick();
        check("hold_grant", entry_grant, 0);
        check("hold_occ", occupancy, 1);
        release_all();

        step(2'b11, 2'b00);
        step(2'b11, 2'b00);
        check("occ5", occupancy, 5);
        check("occ5_af", almost_full, 0);
        apply(2'b01, 2'b00);
        check("occ6", occupancy, 6);
        check("occ6_af", almost_full, 1);
        release_all();
        apply(2'b11, 2'b00);
        check("fill_grant", entry_grant, 2'b11);
        check("occ8", occupancy, 8);
        check("occ8_full", full, 1);
        check("occ8_free", free_slots, 0);
        release_all();
        apply(2'b10, 2'b00);
        check("full_denied", entry_denied, 2'b10);
        check("full_grant", entry_grant, 2'b00);
        check("full_occ", occupancy, 8);
        release_all();

        apply(2'b11, 2'b01);
        check("swap_grant", entry_grant, 2'b01);
        check("swap_denied", entry_denied, 2'b10);
        check("swap_occ", occupancy, 8);
        release_all();

        step(2'b00, 2'b11);
        step(2'b00, 2'b11);
        step(2'b00, 2'b11);
        step(2'b00, 2'b01);
        check("occ_down1", occupancy, 1);
        check("occ_down1_af", almost_full, 0);
        apply(2'b00, 2'b11);
        check("uf_occ", occupancy, 0);
        check("uf_flag", underflow_err, 1);
        check("uf_empty", empty, 1);
        release_all();
        check("uf_sticky", underflow_err, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("uf_cleared", underflow_err, 0);

        // Underflow set and err_clear in the same cycle: the set must win.
        entry_sense = 2'b00;
        exit_sense  = 2'b01;
        repeat (2) tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("uf_set_wins", underflow_err, 1);
        release_all();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        entry_sense = 2'b01;
        tick();
        reset = 1'b1;
        tick();
        check("midrst_grant", entry_grant, 0);
        check("midrst_occ", occupancy, 0);
        check("midrst_free", free_slots, 8);
        reset = 1'b0;
        entry_sense = 2'b00;
        repeat (4) tick();
        check("midrst_no_event", occupancy, 0);
        check("midrst_peak", peak_occupancy, 0);

        step(2'b11, 2'b00);
        step(2'b11, 2'b00);
        step(2'b01, 2'b00);
        step(2'b00, 2'b11);
        step(2'b00, 2'b01);
        check("peak_occ2", occupancy, 2);
`ifdef OCC_PEAK_EN
        check("peak_val", peak_occupancy, 5);
`else
        check("peak_val", peak_occupancy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
